// File: rtl/cache_def.sv
// Shared types and constants for the risk-record cache controller.
// Record layout: trade limit in [31:16], accumulated order value in [15:0].
package cache_def;

    localparam int unsigned LINES     = 16;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned MEM_DEPTH = 122;
    localparam int unsigned IDX_W     = $clog2(LINES);
    localparam int unsigned TAG_W     = ADDR_W - IDX_W;

    localparam int unsigned MAX_MSB = 31;
    localparam int unsigned MAX_LSB = 16;
    localparam int unsigned ACC_MSB = 15;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } line_t;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StFetch,
        StWrite,
        StRespond
    } state_e;

    // Mirrors the memory's update rule so a cached line stays identical to memory.
    function automatic logic [31:0] merge_write(input logic [31:0] rec, input logic change_max,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        r = rec;
        if (change_max) begin
            r[MAX_MSB:MAX_LSB] = wdata[MAX_MSB:MAX_LSB];
            r[ACC_MSB]         = 1'b0;
        end else begin
            r[ACC_MSB:0] = rec[ACC_MSB:0] + wdata[ACC_MSB:0];
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/risk_cache_ctrl_if.sv
// CPU request/response and upstream memory handshake bundle for risk_cache_ctrl.
// The controller uses the slave view; the surrounding environment uses master.
interface risk_cache_ctrl_if;
    import cache_def::*;

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_rw;
    logic              cpu_req_change_max;
    logic [ADDR_W-1:0] cpu_req_index;
    logic [31:0]       cpu_req_data;
    logic              cpu_res_valid;
    logic [31:0]       cpu_res_data;
    logic              cpu_res_err;

    logic [ADDR_W-1:0] mem_index;
    logic              mem_rw;
    logic [31:0]       mem_data;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              mem_written;

    modport slave (
        input  cpu_req_valid, cpu_req_rw, cpu_req_change_max, cpu_req_index, cpu_req_data,
        output cpu_req_ready, cpu_res_valid, cpu_res_data, cpu_res_err,
        output mem_index, mem_rw, mem_data,
        input  mem_ready, mem_rdata, mem_written
    );

    modport master (
        output cpu_req_valid, cpu_req_rw, cpu_req_change_max, cpu_req_index, cpu_req_data,
        input  cpu_req_ready, cpu_res_valid, cpu_res_data, cpu_res_err,
        input  mem_index, mem_rw, mem_data,
        output mem_ready, mem_rdata, mem_written
    );

endinterface

// File: rtl/risk_cache_array.sv
// Line storage: one synchronous write port, one combinational read port.
// Only the valid bits are reset, which flash-clears the whole cache.
module risk_cache_array
    import cache_def::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  line_t            wline_i,
    input  logic [IDX_W-1:0] raddr_i,
    output line_t            rline_o
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= wline_i.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[waddr_i]  <= wline_i.tag;
            data_q[waddr_i] <= wline_i.data;
        end
    end

    always_comb begin
        rline_o.valid = valid_q[raddr_i];
        rline_o.tag   = tag_q[raddr_i];
        rline_o.data  = data_q[raddr_i];
    end

endmodule

// File: rtl/risk_cache_ctrl.sv
// Direct-mapped write-through cache controller for per-client risk records.
// Define RISK_CACHE_STATS_EN to add saturating hit/miss/write counters.
module risk_cache_ctrl
    import cache_def::*;
(
    input  logic             clk,
    input  logic             rst_n,
    risk_cache_ctrl_if.slave bus
`ifdef RISK_CACHE_STATS_EN
    ,
    output logic [15:0]      stat_hits,
    output logic [15:0]      stat_misses,
    output logic [15:0]      stat_writes
`endif
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic              rw_q, rw_d, cm_q, cm_d, wait_q, wait_d;
    logic              mem_rw_q, mem_rw_d, res_err_q, res_err_d;
    logic [ADDR_W-1:0] idx_q, idx_d, mem_index_q, mem_index_d;
    logic [31:0]       wdata_q, wdata_d, mem_data_q, mem_data_d, res_data_q, res_data_d;

    line_t       rline, wline;
    logic        arr_we, hit, req_err;
    logic [31:0] upd_data;

    risk_cache_array u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (arr_we),
        .waddr_i (idx_q[IDX_W-1:0]),
        .wline_i (wline),
        .raddr_i (idx_q[IDX_W-1:0]),
        .rline_o (rline)
    );

    always_comb begin
        hit      = rline.valid && (rline.tag == idx_q[ADDR_W-1:IDX_W]);
        // A max below 2 would be taken by memory as an accumulate, so reject it here.
        req_err  = (idx_q > LastIdx) ||
                   (rw_q && cm_q && (wdata_q[MAX_MSB:MAX_LSB] < 16'd2));
        upd_data = merge_write(rline.data, cm_q, wdata_q);
    end

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        cm_d        = cm_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        mem_rw_d    = mem_rw_q;
        mem_index_d = mem_index_q;
        mem_data_d  = mem_data_q;
        res_err_d   = res_err_q;
        res_data_d  = res_data_q;
        arr_we      = 1'b0;
        wline.valid = 1'b1;
        wline.tag   = idx_q[ADDR_W-1:IDX_W];
        wline.data  = upd_data;

        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req_valid) begin
                    rw_d    = bus.cpu_req_rw;
                    cm_d    = bus.cpu_req_change_max;
                    idx_d   = bus.cpu_req_index;
                    wdata_d = bus.cpu_req_data;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                res_err_d = 1'b0;
                if (req_err) begin
                    res_err_d  = 1'b1;
                    res_data_d = '0;
                    state_d    = StRespond;
                end else if (!rw_q && hit) begin
                    res_data_d = rline.data;
                    state_d    = StRespond;
                end else if (!rw_q) begin
                    mem_index_d = idx_q;
                    wait_d      = 1'b1;
                    state_d     = StFetch;
                end else begin
                    mem_index_d = idx_q;
                    mem_data_d  = cm_q ? {wdata_q[MAX_MSB:MAX_LSB], 16'h0}
                                       : {16'h0, wdata_q[ACC_MSB:0]};
                    mem_rw_d    = 1'b1;
                    wait_d      = 1'b1;
                    state_d     = StWrite;
                end
            end
            StFetch: begin
                if (wait_q) begin
                    wait_d = 1'b0;
                end else if (bus.mem_ready) begin
                    arr_we     = 1'b1;
                    wline.data = bus.mem_rdata;
                    res_data_d = bus.mem_rdata;
                    state_d    = StRespond;
                end
            end
            StWrite: begin
                if (wait_q) begin
                    wait_d = 1'b0;
                end else if (bus.mem_written) begin
                    mem_rw_d = 1'b0;
                    // A miss holds no copy of the record; report what memory presents.
                    res_data_d = hit ? upd_data : bus.mem_rdata;
                    arr_we     = hit;
                    state_d    = StRespond;
                end
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rw_q        <= 1'b0;
            cm_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wait_q      <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_index_q <= '0;
            mem_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            cm_q        <= cm_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            mem_rw_q    <= mem_rw_d;
            mem_index_q <= mem_index_d;
            mem_data_q  <= mem_data_d;
            res_err_q   <= res_err_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.cpu_req_ready = (state_q == StIdle) && rst_n;
    assign bus.cpu_res_valid = (state_q == StRespond);
    assign bus.cpu_res_data  = res_data_q;
    assign bus.cpu_res_err   = res_err_q;
    assign bus.mem_index     = mem_index_q;
    assign bus.mem_rw        = mem_rw_q;
    assign bus.mem_data      = mem_data_q;

`ifdef RISK_CACHE_STATS_EN
    logic [15:0] hits_q, misses_q, writes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
            writes_q <= '0;
        end else if (state_q == StCompare && !req_err) begin
            if (rw_q) begin
                writes_q <= sat_inc(writes_q);
            end else if (hit) begin
                hits_q <= sat_inc(hits_q);
            end else begin
                misses_q <= sat_inc(misses_q);
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
    assign stat_writes = writes_q;
`endif

endmodule

// File: tb/tb_risk_cache_ctrl.sv
// Bench for risk_cache_ctrl: directed scenarios then random traffic against a record-level model.
// A behavioural upstream memory drives the ready/written handshake.
module tb_risk_cache_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    risk_cache_ctrl_if bus ();

`ifdef RISK_CACHE_STATS_EN
    logic [15:0] stat_hits, stat_misses, stat_writes;
`endif

    risk_cache_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RISK_CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
        .stat_writes (stat_writes)
`endif
    );

    // Upstream memory environment.
    logic [31:0] env_mem [128];
    logic [6:0]  env_last_idx = 7'd0;
    logic [6:0]  env_widx = 7'd0;
    logic [31:0] env_wdata = 32'd0;
    logic        env_ready = 1'b1;
    logic        env_written = 1'b0;
    logic        prev_rw = 1'b0;
    int          rd_wait = 0;
    int          wr_cnt = 0;
    int          wr_rises = 0;

    assign bus.mem_ready   = env_ready;
    assign bus.mem_written = env_written;
    assign bus.mem_rdata   = env_ready ? env_mem[bus.mem_index] : 32'h0;

    always @(posedge clk) begin
        prev_rw <= bus.mem_rw;
        if (bus.mem_index != env_last_idx) begin
            env_last_idx <= bus.mem_index;
            rd_wait      <= 3;
            env_ready    <= 1'b0;
        end else if (rd_wait != 0) begin
            rd_wait <= rd_wait - 1;
            if (rd_wait == 1) env_ready <= 1'b1;
        end
        if (bus.mem_rw && !prev_rw) begin
            wr_cnt    <= 2;
            env_widx  <= bus.mem_index;
            env_wdata <= bus.mem_data;
            wr_rises  <= wr_rises + 1;
        end else if (wr_cnt != 0) begin
            wr_cnt <= wr_cnt - 1;
            if (wr_cnt == 1) begin
                env_written <= 1'b1;
                if (env_wdata[31:16] > 16'd1)
                    env_mem[env_widx] = {env_wdata[31:16], 1'b0, env_mem[env_widx][14:0]};
                else
                    env_mem[env_widx][15:0] = env_mem[env_widx][15:0] + env_wdata[15:0];
            end
        end
        if (!bus.mem_rw) env_written <= 1'b0;
    end

    // Reference model: record contents plus which client each line holds.
    logic [31:0] ref_mem [128];
    bit          ref_valid [16];
    int          ref_tag [16];
    int          exp_hits = 0, exp_misses = 0, exp_writes = 0;
    int          n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic rw, input logic cm, input logic [6:0] idx,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        int w;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        @(negedge clk);
        w = 0;
        while (!bus.cpu_req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cpu_req_ready) begin
            check("req_ready_timeout", {31'd0, bus.cpu_req_ready}, 32'd1);
            return;
        end
        bus.cpu_req_valid      = 1'b1;
        bus.cpu_req_rw         = rw;
        bus.cpu_req_change_max = cm;
        bus.cpu_req_index      = idx;
        bus.cpu_req_data       = d;
        @(posedge clk);
        #1 bus.cpu_req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.cpu_res_valid) begin
                rd  = bus.cpu_res_data;
                er  = bus.cpu_res_err;
                lat = i;
                break;
            end
        end
        if (lat < 0) check("res_timeout", {31'd0, bus.cpu_res_valid}, 32'd1);
    endtask

    // op: 0 = read, 1 = accumulate, 2 = set max.
    task automatic run_op(input string tag, input int op, input logic [6:0] idx,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        logic       er;
        logic [6:0] idx_before;
        bit         exp_err, hit;
        int         ln;
        logic [31:0] newrec;
        ln      = int'(idx) % 16;
        hit     = ref_valid[ln] && (ref_tag[ln] == int'(idx) / 16);
        exp_err = (idx >= 7'd122) || (op == 2 && d[31:16] < 16'd2);
        idx_before = bus.mem_index;
        do_req(op != 0, op == 2, idx, d, rd, er, lat);
        if (lat < 0) return;
        check({tag, "/err"}, {31'd0, er}, {31'd0, exp_err});
        if (exp_err) begin
            check({tag, "/err_data"}, rd, 32'd0);
            check({tag, "/err_lat"}, lat, 32'd2);
            check({tag, "/err_idx"}, {25'd0, bus.mem_index}, {25'd0, idx_before});
        end else if (op == 0) begin
            check({tag, "/rdata"}, rd, ref_mem[idx]);
            if (hit) begin
                check({tag, "/hit_lat"}, lat, 32'd2);
                exp_hits++;
            end else begin
                check({tag, "/miss_lat"}, {31'd0, lat >= 3 && lat <= 8}, 32'd1);
                exp_misses++;
            end
            ref_valid[ln] = 1'b1;
            ref_tag[ln]   = int'(idx) / 16;
        end else begin
            newrec = ref_mem[idx];
            if (op == 2) newrec = {d[31:16], 1'b0, newrec[14:0]};
            else         newrec[15:0] = newrec[15:0] + d[15:0];
            ref_mem[idx] = newrec;
            if (hit) check({tag, "/wdata"}, rd, newrec);
            check({tag, "/memrec"}, env_mem[idx], newrec);
            exp_writes++;
        end
    endtask

    initial begin : main
        logic [31:0] rd, v;
        int          lat, rises, op;
        logic [6:0]  idx;
        logic [15:0] mx;

        bus.cpu_req_valid      = 1'b0;
        bus.cpu_req_rw         = 1'b0;
        bus.cpu_req_change_max = 1'b0;
        bus.cpu_req_index      = '0;
        bus.cpu_req_data       = '0;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[5] = 32'h0064_0010;  ref_mem[5] = 32'h0064_0010;
        env_mem[7] = 32'h0064_0001;  ref_mem[7] = 32'h0064_0001;
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst/ready", {31'd0, bus.cpu_req_ready}, 32'd0);
        check("rst/res_valid", {31'd0, bus.cpu_res_valid}, 32'd0);
        check("rst/res_data", bus.cpu_res_data, 32'd0);
        check("rst/mem_rw", {31'd0, bus.mem_rw}, 32'd0);
        check("rst/mem_index", {25'd0, bus.mem_index}, 32'd0);
        check("rst/mem_data", bus.mem_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle/ready", {31'd0, bus.cpu_req_ready}, 32'd1);

        run_op("rd5_miss", 0, 7'd5, 32'd0, rd, lat);
        check("rd5_miss/val", rd, 32'h0064_0010);
        check("rd5_miss/within7", {31'd0, lat >= 3 && lat <= 7}, 32'd1);
        run_op("rd5_hit", 0, 7'd5, 32'd0, rd, lat);
        check("rd5_hit/val", rd, 32'h0064_0010);
        check("rd5_hit/lat", lat, 32'd2);

        run_op("acc5", 1, 7'd5, 32'h0000_0020, rd, lat);
        check("acc5/mem_data", env_wdata, 32'h0000_0020);
        check("acc5/val", rd, 32'h0064_0030);
`ifdef RISK_CACHE_STATS_EN
        check("stats/hits", {16'd0, stat_hits}, 32'd1);
        check("stats/misses", {16'd0, stat_misses}, 32'd1);
        check("stats/writes", {16'd0, stat_writes}, 32'd1);
`endif
        run_op("rd5_after_acc", 0, 7'd5, 32'd0, rd, lat);
        check("rd5_after_acc/val", rd, 32'h0064_0030);

        run_op("max5", 2, 7'd5, 32'h00C8_0000, rd, lat);
        check("max5/val", rd, 32'h00C8_0030);
        rises = wr_rises;
        run_op("max5_bad", 2, 7'd5, 32'h0001_0000, rd, lat);
        check("max5_bad/no_rw", wr_rises, rises);

        run_op("rd122", 0, 7'd122, 32'd0, rd, lat);

        run_op("rd3", 0, 7'd3, 32'd0, rd, lat);
        run_op("rd19", 0, 7'd19, 32'd0, rd, lat);
        check("rd19/miss", {31'd0, lat >= 3}, 32'd1);
        run_op("rd3_again", 0, 7'd3, 32'd0, rd, lat);
        check("rd3_again/miss", {31'd0, lat >= 3}, 32'd1);

        run_op("rd7", 0, 7'd7, 32'd0, rd, lat);
        run_op("acc7_wrap", 1, 7'd7, 32'h0000_FFFF, rd, lat);
        check("acc7_wrap/val", rd, 32'h0064_0000);

        // Cache client 9, then reset in the middle of a write to it.
        run_op("rd9", 0, 7'd9, 32'd0, rd, lat);
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_rw    = 1'b1;
        bus.cpu_req_change_max = 1'b0;
        bus.cpu_req_index = 7'd9;
        bus.cpu_req_data  = 32'h0000_0003;
        @(posedge clk);
        #1 bus.cpu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midwr/rw_high", {31'd0, bus.mem_rw}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwr/rw_low", {31'd0, bus.mem_rw}, 32'd0);
        check("midwr/ready_low", {31'd0, bus.cpu_req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.cpu_res_valid) lat++;
        end
        check("midwr/no_resp", lat, 32'd0);
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_mem[9] = env_mem[9];
        exp_hits = 0;
        exp_misses = 0;
        exp_writes = 0;
        run_op("rd9_after_rst", 0, 7'd9, 32'd0, rd, lat);
        check("rd9_after_rst/miss", {31'd0, lat >= 3}, 32'd1);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) idx = 7'($urandom_range(122, 127));
            else                           idx = 7'($urandom_range(0, 47));
            op = int'($urandom_range(0, 2));
            v  = $urandom;
            if (op == 2) begin
                mx = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 1))
                                                 : 16'($urandom_range(2, 65535));
                v  = {mx, v[15:0]};
            end
            run_op("rand", op, idx, v, rd, lat);
        end
`ifdef RISK_CACHE_STATS_EN
        check("rand/stat_hits", {16'd0, stat_hits}, exp_hits);
        check("rand/stat_misses", {16'd0, stat_misses}, exp_misses);
        check("rand/stat_writes", {16'd0, stat_writes}, exp_writes);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
